// File: rtl/reg_file_8x16_if.sv
// Bus bundle for the 8x16 register file: write port, two operand read ports,
// debug read port and the accepted-write counter.
interface reg_file_8x16_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [7:0]        wr_count;

    modport master (
        output we, wr_addr, wr_data, rd_addr_a, rd_addr_b, dbg_addr,
        input  rd_data_a, rd_data_b, dbg_data, wr_count
    );

    modport slave (
        input  we, wr_addr, wr_data, rd_addr_a, rd_addr_b, dbg_addr,
        output rd_data_a, rd_data_b, dbg_data, wr_count
    );
endinterface

// File: rtl/reg_file_8x16.sv
// Eight-entry register file with R0 hardwired to zero, two combinational read
// ports with optional same-cycle write forwarding, and an unbypassed debug port.
module reg_file_8x16 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input logic            clk,
    input logic            rst,
    reg_file_8x16_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [0:DEPTH-1];
    logic [7:0]        r_wr_count;

    logic              w_wr_accept;
    logic              w_byp_a;
    logic              w_byp_b;

    assign w_wr_accept = bus.we && (bus.wr_addr != '0);

    // Plain flop array: the async clear rules out RAM inference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_wr_accept) begin
            r_regs[bus.wr_addr] <= bus.wr_data;
            r_wr_count          <= r_wr_count + 8'd1;
        end
    end

    // Forwarding is suppressed during reset so every read is zero while rst=1.
    assign w_byp_a = (BYPASS != 0) && !rst && w_wr_accept && (bus.rd_addr_a == bus.wr_addr);
    assign w_byp_b = (BYPASS != 0) && !rst && w_wr_accept && (bus.rd_addr_b == bus.wr_addr);

    assign bus.rd_data_a = (bus.rd_addr_a == '0) ? '0 :
                           w_byp_a               ? bus.wr_data :
                                                   r_regs[bus.rd_addr_a];

    assign bus.rd_data_b = (bus.rd_addr_b == '0) ? '0 :
                           w_byp_b               ? bus.wr_data :
                                                   r_regs[bus.rd_addr_b];

    assign bus.dbg_data  = (bus.dbg_addr == '0) ? '0 : r_regs[bus.dbg_addr];
    assign bus.wr_count  = r_wr_count;
endmodule

// File: doc/reg_file_8x16.md
Name: reg_file_8x16

Overview:
- Eight-entry general-purpose register file for the FPGA RISC datapath.
- Sits directly downstream of the 3-bit destination-register select mux; that mux's 3-bit output drives wr_addr here.
- Two combinational read ports (rs/rt operands), one synchronous write port, and a debug read port for board display.
- R0 reads as zero at all times.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width in bits. Fixed at 3, matching the 3-bit register-select path; depth = 2**ADDR_W = 8.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return the stored value only.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable, sampled at the rising edge of clk.
- wr_addr  input  ADDR_W  destination register, from the 3-bit select mux.
- wr_data  input  DATA_W  write-back data.
- rd_addr_a  input  ADDR_W  read port A address (rs).
- rd_addr_b  input  ADDR_W  read port B address (rt).
- rd_data_a  output  DATA_W  read port A data.
- rd_data_b  output  DATA_W  read port B data.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  DATA_W  debug read data; never bypassed.
- wr_count  output  8  count of accepted writes, for debug.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst=1:
  - all eight registers = 0; wr_count = 0;
  - all read outputs = 0 combinationally;
  - writes are ignored.
- Reset release: the first write can occur at the first rising edge of clk with rst=0.
- Reset mid-operation: an rst assertion between edges clears the registers immediately, and nothing pending survives. An rst assertion coincident with a write edge takes priority, so the write is lost.
- Write:
  - At the rising edge of clk, if we=1 and wr_addr != 0, then reg[wr_addr] <= wr_data and wr_count <= wr_count + 1.
  - wr_count wraps 255 -> 0.
  - A write with wr_addr = 0 is discarded: R0 is unchanged and wr_count does not increment.
  - A write with we=0 changes nothing.
- Read (combinational, zero latency):
  - If rd_addr_x = 0, rd_data_x = 0.
  - Otherwise, if BYPASS=1, we=1 and rd_addr_x = wr_addr, rd_data_x = wr_data (forwarding for a same-cycle write-back).
  - Otherwise, rd_data_x = reg[rd_addr_x].
  - The bypass never applies to address 0.
- Port independence: both read ports may address the same register, and both are bypassed independently.
- Debug port: dbg_data = reg[dbg_addr] (0 for address 0), with no bypass. It reflects the stored state, which updates one edge after the write.
- Reads have no side effects, and any address is legal. No X propagation: every output is driven from reset onward.
- Width rules: wr_data is stored at full DATA_W with no truncation and no sign handling.
- Target: RTL is a plain register array with an async-reset always block; no inferred RAM, because of the async clear.

Test Plan:
- Reset state: assert rst=1 mid-simulation after registers hold data -> rd_data_a, rd_data_b and dbg_data = 0x0000 for all 8 addresses, wr_count = 0, immediately without a clock edge.
- Basic write/read: we=1, wr_addr=3, wr_data=0xBEEF, one edge, then rd_addr_a=3 -> rd_data_a = 0xBEEF; dbg_addr=3 -> dbg_data = 0xBEEF; wr_count = 1.
- R0 hardwired: we=1, wr_addr=0, wr_data=0x1234, one edge -> rd_data_a/b with address 0 = 0x0000, wr_count unchanged.
- Bypass: R5 = 0x0011. Present we=1, wr_addr=5, wr_data=0xA5A5 with rd_addr_a=5, rd_addr_b=5, dbg_addr=5 before the edge -> rd_data_a = rd_data_b = 0xA5A5 and dbg_data = 0x0011. After the edge, dbg_data = 0xA5A5. With BYPASS=0, rd_data_a = 0x0011 before the edge.
- Full sweep plus counter wrap:
  - Write reg[i] = 0x1000+i for i=1..7 -> all ports read back correctly, and reg[0] reads 0.
  - Then perform 256 total accepted writes -> wr_count returns to 0.
- Reset racing write: rst rises in the same cycle as we=1, wr_addr=2, wr_data=0xFFFF -> after rst falls, R2 = 0x0000 and wr_count = 0.
